// File: rtl/chnl_tx_arb_pkg.sv
// Shared definitions for the chnl_tx_arb frame arbiter: FSM state encoding,
// the tag-header magic value and the header field layout. The header helper
// is only used when CHNL_TX_ARB_TAG_EN is defined.
package chnl_tx_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2,
        S_PAD  = 2'd3
    } state_t;

    localparam logic [15:0] TAG_MAGIC     = 16'hA5C3;
    localparam int          HDR_SRC_LSB   = 0;
    localparam int          HDR_SEQ_LSB   = 8;
    localparam int          HDR_MAGIC_LSB = 16;

    // Header layout: {magic[15:0], seq[7:0], 4'h0, src[3:0]}
    function automatic logic [31:0] make_header(input logic [7:0] seq,
                                                input logic [3:0] src);
        logic [31:0] h;
        h = '0;
        h[HDR_MAGIC_LSB +: 16] = TAG_MAGIC;
        h[HDR_SEQ_LSB   +: 8]  = seq;
        h[HDR_SRC_LSB   +: 4]  = src;
        return h;
    endfunction

endpackage

// File: rtl/chnl_tx_arb_rr_arbiter.sv
// Combinational round-robin picker: returns the first set request at or
// above ptr (wrapping modulo N) as a one-hot grant plus its index.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    // Scan from ptr upward and latch onto the first active requester
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/chnl_tx_arb.sv
// Round-robin, frame-granular arbiter in front of chnl_tx. A grant lasts for
// exactly FRAME_BEATS accepted beats; a requester that goes quiet for
// STALL_CYCLES cycles mid-frame has its frame completed with PAD_WORD beats.
// Optional feature macro: CHNL_TX_ARB_TAG_EN adds a header beat carrying a
// frame sequence number and the source id at the start of every frame.
module chnl_tx_arb
    import chnl_tx_arb_pkg::*;
#(
    parameter int                  N_REQ        = 4,
    parameter int                  TX_WIDTH     = 32,
    parameter int                  FRAME_BEATS  = 4,
    parameter int                  STALL_CYCLES = 64,
    parameter logic [TX_WIDTH-1:0] PAD_WORD     = '0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [N_REQ-1:0]          req_val_i,
    input  logic [N_REQ*TX_WIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]          req_rdy_o,
    output logic                      out_val_o,
    output logic [TX_WIDTH-1:0]       out_data_o,
    input  logic                      out_rdy_i,
    output logic [N_REQ-1:0]          grant_o,
    output logic                      pad_o
);

    localparam int PW = $clog2(N_REQ);
    localparam int BW = $clog2(FRAME_BEATS + 1);
    // A zero STALL_CYCLES disables padding; keep a 1-bit counter in that case
    localparam int SW = (STALL_CYCLES > 0) ? $clog2(STALL_CYCLES + 1) : 1;

    localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_BEATS - 1);
    localparam logic [SW-1:0] STALL_LIM = SW'(STALL_CYCLES);
    localparam logic [SW-1:0] STALL_MAX = '1;
    localparam logic [PW-1:0] LAST_REQ  = PW'(N_REQ - 1);

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [PW-1:0]     gidx_q, gidx_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [SW-1:0]     stall_q, stall_d;
`ifdef CHNL_TX_ARB_TAG_EN
    logic [7:0]        seq_q, seq_d;
`endif

    logic [N_REQ-1:0]    arb_grant;
    logic [PW-1:0]       arb_idx;
    logic                arb_any;
    logic                g_val;
    logic [TX_WIDTH-1:0] g_data;
    logic [PW-1:0]       ptr_next;
    logic [SW-1:0]       stall_inc;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req   (req_val_i),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign g_val     = req_val_i[gidx_q];
    assign g_data    = req_data_i[int'(gidx_q)*TX_WIDTH +: TX_WIDTH];
    assign ptr_next  = (gidx_q == LAST_REQ) ? '0 : gidx_q + 1'b1;
    assign stall_inc = (stall_q == STALL_MAX) ? stall_q : stall_q + 1'b1;
    assign grant_o   = grant_q;

    // State, ownership and counters; reset drops any frame in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
            stall_q <= '0;
`ifdef CHNL_TX_ARB_TAG_EN
            seq_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            stall_q <= stall_d;
`ifdef CHNL_TX_ARB_TAG_EN
            seq_q   <= seq_d;
`endif
        end
    end

    // Next-state logic and the output mux for the current owner
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        ptr_d      = ptr_q;
        beat_d     = beat_q;
        stall_d    = stall_q;
`ifdef CHNL_TX_ARB_TAG_EN
        seq_d      = seq_q;
`endif
        out_val_o  = 1'b0;
        out_data_o = '0;
        req_rdy_o  = '0;
        pad_o      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Grant only; the first beat moves on the following cycle
                if (arb_any) begin
                    grant_d = arb_grant;
                    gidx_d  = arb_idx;
                    beat_d  = '0;
                    stall_d = '0;
`ifdef CHNL_TX_ARB_TAG_EN
                    state_d = S_HDR;
`else
                    state_d = S_DATA;
`endif
                end
            end

`ifdef CHNL_TX_ARB_TAG_EN
            S_HDR: begin
                out_val_o  = 1'b1;
                out_data_o = TX_WIDTH'(make_header(seq_q, 4'(gidx_q)));
                if (out_rdy_i) begin
                    seq_d   = seq_q + 8'd1;
                    beat_d  = beat_q + 1'b1;
                    stall_d = '0;
                    if (beat_q == LAST_BEAT) begin
                        ptr_d   = ptr_next;
                        grant_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
`endif

            S_DATA: begin
                out_val_o  = g_val;
                out_data_o = g_data;
                req_rdy_o  = grant_q & {N_REQ{out_rdy_i}};
                if (g_val && out_rdy_i) begin
                    beat_d  = beat_q + 1'b1;
                    stall_d = '0;
                    if (beat_q == LAST_BEAT) begin
                        ptr_d   = ptr_next;
                        grant_d = '0;
                        state_d = S_IDLE;
                    end
                end else if (!g_val) begin
                    // Only an absent requester counts as a stall, not backpressure
                    stall_d = stall_inc;
                    if (STALL_CYCLES != 0 && stall_inc == STALL_LIM) begin
                        pad_o   = 1'b1;
                        state_d = S_PAD;
                    end
                end
            end

            S_PAD: begin
                out_val_o  = 1'b1;
                out_data_o = PAD_WORD;
                if (out_rdy_i) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        ptr_d   = ptr_next;
                        grant_d = '0;
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_chnl_tx_arb.sv
// Bench for chnl_tx_arb: per-requester data queues feed the DUT, a
// frame-level reference model predicts the accepted output stream.
module tb_chnl_tx_arb;

    localparam int N     = 4;
    localparam int W     = 32;
    localparam int FB    = 4;
    localparam int STALL = 64;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_val;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_rdy;
    logic             out_val;
    logic [W-1:0]     out_data;
    logic             out_rdy;
    logic [N-1:0]     grant;
    logic             pad;

    always #5 clk = ~clk;

    chnl_tx_arb #(
        .N_REQ(N), .TX_WIDTH(W), .FRAME_BEATS(FB), .STALL_CYCLES(STALL), .PAD_WORD('0)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_val_i  (req_val),
        .req_data_i (req_data),
        .req_rdy_o  (req_rdy),
        .out_val_o  (out_val),
        .out_data_o (out_data),
        .out_rdy_i  (out_rdy),
        .grant_o    (grant),
        .pad_o      (pad)
    );

    logic [W-1:0] q [N][$];
    logic [W-1:0] exp_data [$];
    int           exp_src  [$];
    logic [W-1:0] log_data [$];
    int           log_src  [$];
    int           log_cyc  [$];
    int           last_pop_cyc [N];
    int           cyc, lc, pad_cnt, pad_cyc, rdy_mode;
    bit           bad_rdy;
    int           n_pass, n_total;

    task automatic chk(input string tag, input longint obs, input longint expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    function automatic int oh2idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++)
            if (v[i]) r = (r < 0) ? i : 99;
        return r;
    endfunction

    function automatic logic rdy_fn(input int c);
        if (rdy_mode == 0) return 1'b1;
        if (c < 40)        return (c % 2) == 0;
        if (c < 120)       return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive();
        out_rdy = rdy_fn(lc);
        for (int k = 0; k < N; k++) begin
            req_val[k] = (q[k].size() != 0);
            if (q[k].size() != 0) req_data[k*W +: W] = q[k][0];
            else                  req_data[k*W +: W] = '0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        drive();
        #1;
        if (out_val && out_rdy) begin
            log_data.push_back(out_data);
            log_src.push_back(oh2idx(grant));
            log_cyc.push_back(cyc);
        end
        if (pad) begin
            pad_cnt++;
            pad_cyc = cyc;
        end
        if ((req_rdy & ~grant) != '0) bad_rdy = 1'b1;
        for (int k = 0; k < N; k++)
            if (req_val[k] && req_rdy[k]) begin
                void'(q[k].pop_front());
                last_pop_cyc[k] = cyc;
            end
        cyc++;
        lc++;
    endtask

    task automatic clear_logs();
        log_data.delete();
        log_src.delete();
        log_cyc.delete();
        pad_cnt = 0;
        pad_cyc = -1;
        bad_rdy = 1'b0;
        lc      = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) q[k].delete();
        drive();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic push_n(input int k, input int n);
        for (int i = 0; i < n; i++) q[k].push_back($urandom() | 32'h1);
    endtask

    // Frame-level prediction: round-robin over requesters with data left,
    // each frame FB beats (optional header first), short frames padded with 0
    task automatic build_model();
        logic [W-1:0] m [N][$];
        int ptr, seq, k, nd;
        ptr = 0;
        seq = 0;
        exp_data.delete();
        exp_src.delete();
        for (int i = 0; i < N; i++) m[i] = q[i];
        while (1) begin
            k = -1;
            for (int i = 0; i < N; i++)
                if (k < 0 && m[(ptr + i) % N].size() != 0) k = (ptr + i) % N;
            if (k < 0) break;
`ifdef CHNL_TX_ARB_TAG_EN
            exp_data.push_back({16'hA5C3, 8'(seq), 4'h0, 4'(k)});
            exp_src.push_back(k);
            seq = (seq + 1) % 256;
            nd  = FB - 1;
`else
            nd  = FB;
`endif
            for (int b = 0; b < nd; b++) begin
                if (m[k].size() != 0) exp_data.push_back(m[k].pop_front());
                else                  exp_data.push_back('0);
                exp_src.push_back(k);
            end
            ptr = (k + 1) % N;
        end
    endtask

    task automatic run_check(input string tag, input int budget);
        int n, lim;
        n = 0;
        while (log_data.size() < exp_data.size() && n < budget) begin
            step();
            n++;
        end
        repeat (4) step();
        chk({tag, "_beats"}, log_data.size(), exp_data.size());
        lim = (log_data.size() < exp_data.size()) ? log_data.size() : exp_data.size();
        for (int i = 0; i < lim; i++) begin
            chk($sformatf("%s_data%0d", tag, i), log_data[i], exp_data[i]);
            chk($sformatf("%s_src%0d", tag, i), log_src[i], exp_src[i]);
        end
        chk({tag, "_idle"}, {out_val, grant}, 0);
        chk({tag, "_rdy_excl"}, bad_rdy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass   = 0;
        n_total  = 0;
        cyc      = 0;
        rdy_mode = 0;
        rst_n    = 1'b0;
        out_rdy  = 1'b1;
        req_val  = '1;
        req_data = '0;
        clear_logs();
        #12;
        chk("reset_outputs", {out_val, grant, req_rdy, pad}, 0);

        // 1: single requester, two back-to-back frames with one idle cycle
        do_reset();
        push_n(0, 8);
        build_model();
        run_check("t1", 300);
        chk("t1_gap", (log_cyc.size() > 4) ? log_cyc[4] - log_cyc[3] : -1, 2);
        chk("t1_pad", pad_cnt, 0);

        // 2: all requesters busy, order 0,1,2,3,0
        do_reset();
        push_n(0, 8);
        for (int k = 1; k < N; k++) push_n(k, 4);
        build_model();
        run_check("t2", 400);
        chk("t2_pad", pad_cnt, 0);

        // 3: requester 2 stalls after two beats and gets padded out
        do_reset();
        push_n(2, 2);
        push_n(3, 4);
        build_model();
        run_check("t3", 400);
        chk("t3_pad_cnt", pad_cnt, 1);
        chk("t3_pad_cyc", pad_cyc, last_pop_cyc[2] + STALL);

        // 4: toggling then long backpressure; no padding may occur
        do_reset();
        rdy_mode = 1;
        push_n(0, 12);
        push_n(1, 12);
        build_model();
        run_check("t4", 500);
        chk("t4_pad", pad_cnt, 0);
        rdy_mode = 0;

        // 5: reset in the middle of a frame from requester 2
        do_reset();
        push_n(1, 4);
        push_n(2, 8);
        for (int n = 0; n < 100 && q[2].size() > 6; n++) step();
        chk("t5_midframe", q[2].size(), 6);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_reset_outputs", {out_val, grant, req_rdy, pad}, 0);
        repeat (2) step();
        push_n(1, 4);
        push_n(2, 2);
        @(negedge clk);
        drive();
        rst_n = 1'b1;
        clear_logs();
        build_model();
        run_check("t5", 400);
        chk("t5_first_grant", (log_src.size() > 0) ? log_src[0] : -1, 1);

        // 6: requester 1 alone for two frames
        do_reset();
        push_n(1, 6);
        build_model();
        run_check("t6", 400);
`ifdef CHNL_TX_ARB_TAG_EN
        chk("t6_hdr0", (log_data.size() > 0) ? log_data[0] : 0, 32'hA5C30001);
        chk("t6_hdr1", (log_data.size() > 4) ? log_data[4] : 0, 32'hA5C30101);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
